// File: rtl/ring_token_arbiter.sv
// ring_token_arbiter
// Per-core local token arbiter between the ring token slot and the core's
// ring clients. Grants the token round-robin to one local requester, lets it
// hold the token while it drives the ring (bounded by MAXHOLD), then passes
// the token downstream as a registered one-cycle pulse.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | no token at this node; waiting for tokenIn
//   HAVE  | token held locally, no grantee (out of reset or deferred pass)
//   HOLD  | token owned by local client `owner`, which may drive the ring
module ring_token_arbiter #(
  parameter int NREQ       = 4,
  parameter int MAXHOLD    = 16,
  parameter bit INIT_TOKEN = 1'b0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            tokenIn,
  output logic            tokenOut,
  input  logic [NREQ-1:0] want,
  input  logic [NREQ-1:0] drive,
  output logic [NREQ-1:0] acquire,
  output logic [2:0]      owner,
  output logic            holding,
  output logic            protoErr,
  output logic            timeoutErr
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAXHOLD + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HAVE = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam state_t RESET_STATE = INIT_TOKEN ? HAVE : IDLE;

  state_t          state, stateNext;
  logic [IW-1:0]   ownerIdx, ownerNext;
  logic [CW-1:0]   holdCnt, holdCntNext;
  logic            tokenOutNext;
  logic            holdingNext;
  logic            protoErrNext;
  logic            timeoutErrNext;
  logic            avail;
  logic            winValid;
  logic [IW-1:0]   winIdx;
  logic [IW-1:0]   candIdx;

  assign owner = 3'(ownerIdx);

  // Round-robin pick: first requester scanning upward from owner+1, wrapping.
  always_comb begin
    winValid = 1'b0;
    winIdx   = '0;
    candIdx  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      candIdx = IW'((int'(ownerIdx) + i) % NREQ);
      if (!winValid && want[candIdx]) begin
        winValid = 1'b1;
        winIdx   = candIdx;
      end
    end
  end

  // Next-state, grant and release decisions.
  always_comb begin
    stateNext      = state;
    ownerNext      = ownerIdx;
    holdCntNext    = holdCnt;
    tokenOutNext   = 1'b0;
    holdingNext    = holding;
    protoErrNext   = protoErr;
    timeoutErrNext = timeoutErr;
    acquire        = '0;

    avail = ((state == IDLE) && tokenIn) || (state == HAVE);

    // A second token arriving while we already hold one is dropped.
    if (tokenIn && (state != IDLE)) begin
      protoErrNext = 1'b1;
    end

    if (avail) begin
      if (winValid) begin
        acquire[winIdx] = ~reset;
        ownerNext       = winIdx;
        holdingNext     = 1'b1;
        holdCntNext     = '0;
        stateNext       = HOLD;
      end else if (tokenOut) begin
        // Token pulsed out last cycle; keep this one a cycle so the
        // downstream never sees two back-to-back pulses.
        stateNext = HAVE;
      end else begin
        tokenOutNext = 1'b1;
        stateNext    = IDLE;
      end
    end else if (state == HOLD) begin
      if (holdCnt != CW'(MAXHOLD)) begin
        holdCntNext = holdCnt + CW'(1);
      end
      if (!drive[ownerIdx]) begin
        tokenOutNext = 1'b1;
        holdingNext  = 1'b0;
        stateNext    = IDLE;
      end else if (holdCnt == CW'(MAXHOLD - 1)) begin
        timeoutErrNext = 1'b1;
        tokenOutNext   = 1'b1;
        holdingNext    = 1'b0;
        stateNext      = IDLE;
      end
    end
  end

  // State and output registers; reset re-creates the token only on the master.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= RESET_STATE;
      ownerIdx   <= IW'(NREQ - 1);
      holdCnt    <= '0;
      tokenOut   <= 1'b0;
      holding    <= 1'b0;
      protoErr   <= 1'b0;
      timeoutErr <= 1'b0;
    end else begin
      state      <= stateNext;
      ownerIdx   <= ownerNext;
      holdCnt    <= holdCntNext;
      tokenOut   <= tokenOutNext;
      holding    <= holdingNext;
      protoErr   <= protoErrNext;
      timeoutErr <= timeoutErrNext;
    end
  end

  // Ring invariants: single grant, no grant while held, no back-to-back pass.
  aOneGrant: assert property (@(posedge clock) disable iff (reset) $onehot0(acquire));
  aNoGrantHeld: assert property (@(posedge clock) disable iff (reset) holding |-> (acquire == '0));
  aNoDoublePass: assert property (@(posedge clock) disable iff (reset) tokenOut |=> !tokenOut);

endmodule
